// File: rtl/rx_sram_writer_if.sv
// Rx FIFO pop handshake and SRAM write port bundle for rx_sram_writer.
// slave = the writer's view; master = the driving environment.
interface rx_sram_writer_if #(
    parameter int ADDR_W = 8
);
    logic              rx_empty;
    logic              rx_ready;
    logic [11:0]       rx_word;
    logic              rx_order;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [7:0]        sram_wdata;
    logic              sram_full;
    logic [ADDR_W:0]   wr_count;
    logic [7:0]        err_count;
    logic [3:0]        err_flags;

    modport slave (
        input  rx_empty, rx_ready, rx_word,
        output rx_order, sram_we, sram_addr, sram_wdata, sram_full,
               wr_count, err_count, err_flags
    );

    modport master (
        output rx_empty, rx_ready, rx_word,
        input  rx_order, sram_we, sram_addr, sram_wdata, sram_full,
               wr_count, err_count, err_flags
    );
endinterface

// File: rtl/rx_sram_writer.sv
// Pops Rx FIFO words, drops line-error words, writes clean bytes sequentially to SRAM.
// Define PARITY_CHECK_EN to also drop (and flag) words with bad parity.
module rx_sram_writer #(
    parameter int ADDR_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic            baud_clk,
    input  logic            rst,
    input  logic            clr,
    rx_sram_writer_if.slave bus
);
`ifdef PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE, S_REQ1, S_REQ2, S_WAIT, S_CAPTURE, S_CHECK, S_WRITE, S_DROP, S_FULL
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [3:0]        flags_q, flags_d;
    logic [2:0]        line_err_q, line_err_d;
    logic              pe_q, pe_d;
    logic [7:0]        data_q, data_d;
    logic              par_bad;

    assign par_bad = (^bus.rx_word[8:0]) != ODD_PARITY;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_cnt_d   = wr_cnt_q;
        err_cnt_d  = err_cnt_q;
        flags_d    = flags_q;
        line_err_d = line_err_q;
        pe_d       = pe_q;
        data_d     = data_q;
        case (state_q)
            S_IDLE:    if (bus.rx_ready && !bus.rx_empty) state_d = S_REQ1;
            S_REQ1:    state_d = S_REQ2;
            S_REQ2:    state_d = S_WAIT;
            S_WAIT:    state_d = S_CAPTURE;
            S_CAPTURE: begin
                line_err_d = bus.rx_word[11:9];
                pe_d       = PAR_EN && par_bad;
                data_d     = bus.rx_word[7:0];
                state_d    = S_CHECK;
            end
            S_CHECK:   state_d = (line_err_q == 3'b000 && !pe_q) ? S_WRITE : S_DROP;
            S_WRITE: begin
                addr_d   = addr_q + 1'b1;
                wr_cnt_d = wr_cnt_q + 1'b1;
                // Last location written: park in FULL rather than wrap onto old data.
                state_d  = (addr_q == ADDR_MAX) ? S_FULL : S_IDLE;
            end
            S_DROP: begin
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                flags_d = flags_q | {line_err_q, pe_q};
                state_d = S_IDLE;
            end
            S_FULL:    state_d = S_FULL;
            default:   state_d = S_IDLE;
        endcase
        if (clr) begin
            state_d    = S_IDLE;
            addr_d     = '0;
            wr_cnt_d   = '0;
            err_cnt_d  = '0;
            flags_d    = '0;
            line_err_d = '0;
            pe_d       = 1'b0;
            data_d     = '0;
        end
    end

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wr_cnt_q   <= '0;
            err_cnt_q  <= '0;
            flags_q    <= '0;
            line_err_q <= '0;
            pe_q       <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_cnt_q   <= wr_cnt_d;
            err_cnt_q  <= err_cnt_d;
            flags_q    <= flags_d;
            line_err_q <= line_err_d;
            pe_q       <= pe_d;
            data_q     <= data_d;
        end
    end

    assign bus.rx_order   = (state_q == S_REQ1) || (state_q == S_REQ2);
    assign bus.sram_we    = (state_q == S_WRITE);
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = (state_q == S_WRITE) ? data_q : 8'h00;
    assign bus.sram_full  = (state_q == S_FULL);
    assign bus.wr_count   = wr_cnt_q;
    assign bus.err_count  = err_cnt_q;
    assign bus.err_flags  = flags_q;
endmodule
